// File: rtl/wb_master_arbiter_if.sv
// wb_master_arbiter_if: bundles the requester-side and interconnect-side
// Wishbone classic signals of the master-port arbiter.
//   wbm_* : NUM_MASTERS requesters, packed [master][bit] (master k at k*W)
//   wbs_* : the single shared master port towards the interconnect wb_io
// Modports:
//   master : the arbiter's view (drives wbs_* requests and wbm_* responses)
//   slave  : the surrounding system (requesters + interconnect)
interface wb_master_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0][31:0] wbm_adr_i;
  logic [NUM_MASTERS-1:0][31:0] wbm_dat_i;
  logic [NUM_MASTERS-1:0][3:0]  wbm_sel_i;
  logic [NUM_MASTERS-1:0]       wbm_we_i;
  logic [NUM_MASTERS-1:0]       wbm_cyc_i;
  logic [NUM_MASTERS-1:0]       wbm_stb_i;
  logic [31:0]                  wbm_dat_o;
  logic [NUM_MASTERS-1:0]       wbm_ack_o;
  logic [NUM_MASTERS-1:0]       wbm_err_o;
  logic [NUM_MASTERS-1:0]       wbm_rty_o;

  logic [31:0] wbs_adr_o;
  logic [31:0] wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o;
  logic        wbs_cyc_o;
  logic        wbs_stb_o;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_i;
  logic        wbs_err_i;
  logic        wbs_rty_i;

  modport master (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );

  modport slave (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: round-robin arbiter sharing one Wishbone classic master
// port between NUM_MASTERS requesters, with a per-transfer watchdog.
// Ports:
//   wb_clk_i  : clock
//   wb_rst_i  : asynchronous active-high reset
//   bus       : wb_master_arbiter_if.master (requesters + interconnect side)
//   grant_o   : one-hot current owner (registered)
//   timeout_o : one-cycle pulse when the watchdog aborts a transfer
// Ownership is held for the whole cyc assertion of the owner. A stalled
// strobe (no ack/err/rty) for TIMEOUT_CYCLES cycles ends the transfer with
// err to the owner; TIMEOUT_CYCLES=0 disables the watchdog.

// Per-requester response steering: only the owner sees slave responses, and
// the abort cycle returns err to it.
module wb_master_arbiter_lane (
  input  logic gnt,
  input  logic busy,
  input  logic abort,
  input  logic ack,
  input  logic err,
  input  logic rty,
  output logic ack_o,
  output logic err_o,
  output logic rty_o
);
  assign ack_o = gnt & busy & ack;
  assign err_o = gnt & ((busy & err) | abort);
  assign rty_o = gnt & busy & rty;
endmodule

module wb_master_arbiter #(
  parameter int NUM_MASTERS    = 2,   // 2..4
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8    // 2**CNT_W > TIMEOUT_CYCLES
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_master_arbiter_if.master    bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr;
  logic [CNT_W-1:0] wdog;

  logic             busy, abort, resp, stall, expire;
  logic             req_found;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] rr_next;

  assign busy  = (state == BUSY);
  assign abort = (state == ABORT);
  assign resp  = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
  assign stall = busy & bus.wbs_stb_o & ~resp;
  // A response in the expiry cycle makes it a non-stall cycle, so it wins.
  assign expire = (TIMEOUT_CYCLES != 0) && stall &&
                  (wdog == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rr_next = (owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;

  // First requester with cyc high, searching upward from rr with wrap.
  always_comb begin
    int k;
    k         = 0;
    req_found = 1'b0;
    req_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      k = (int'(rr) + i) % NUM_MASTERS;
      if (!req_found && bus.wbm_cyc_i[k]) begin
        req_found = 1'b1;
        req_idx   = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      grant_o   <= '0;
      owner     <= '0;
      rr        <= '0;
      wdog      <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (req_found) begin
            owner   <= req_idx;
            grant_o <= NUM_MASTERS'(1) << req_idx;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.wbm_cyc_i[owner]) begin
            state   <= IDLE;
            grant_o <= '0;
            rr      <= rr_next;
            wdog    <= '0;
          end else if (expire) begin
            state     <= ABORT;
            timeout_o <= 1'b1;
            wdog      <= '0;
          end else if (stall) begin
            wdog <= wdog + 1'b1;
          end else begin
            wdog <= '0;
          end
        end
        ABORT: begin
          state   <= IDLE;
          grant_o <= '0;
          rr      <= rr_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shared port follows the owner only while BUSY; zeros otherwise so a
  // reset or abort drops cyc/stb without waiting for a clock edge.
  assign bus.wbs_adr_o = busy ? bus.wbm_adr_i[owner] : '0;
  assign bus.wbs_dat_o = busy ? bus.wbm_dat_i[owner] : '0;
  assign bus.wbs_sel_o = busy ? bus.wbm_sel_i[owner] : '0;
  assign bus.wbs_we_o  = busy & bus.wbm_we_i[owner];
  assign bus.wbs_cyc_o = busy & bus.wbm_cyc_i[owner];
  assign bus.wbs_stb_o = busy & bus.wbm_stb_i[owner];
  assign bus.wbm_dat_o = bus.wbs_dat_i;

  logic [NUM_MASTERS-1:0] ack_v, err_v, rty_v;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_lane
    wb_master_arbiter_lane u_lane (
      .gnt   (grant_o[g]),
      .busy  (busy),
      .abort (abort),
      .ack   (bus.wbs_ack_i),
      .err   (bus.wbs_err_i),
      .rty   (bus.wbs_rty_i),
      .ack_o (ack_v[g]),
      .err_o (err_v[g]),
      .rty_o (rty_v[g])
    );
  end

  assign bus.wbm_ack_o = ack_v;
  assign bus.wbm_err_o = err_v;
  assign bus.wbm_rty_o = rty_v;
endmodule

// File: tb/tb_wb_master_arbiter.sv
module tb_wb_master_arbiter;
  localparam int NM = 2;
  localparam int TO = 8;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic [NM-1:0] grant_o;
  logic          timeout_o;

  wb_master_arbiter_if #(.NUM_MASTERS(NM)) bus();

  wb_master_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .bus       (bus),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // One record per clock cycle, applied in order.
  typedef struct {
    bit       rst;
    bit [1:0] cyc;
    bit [1:0] stb;
    bit       ack;
    bit       mux;   // shared port expected to follow the owner
    bit [1:0] gnt;
    bit       wcyc;
    bit [1:0] acko;
  } vec_t;

  function automatic vec_t v(bit rst, bit [1:0] cyc, bit [1:0] stb, bit ack,
                             bit mux, bit [1:0] gnt, bit wcyc, bit [1:0] acko);
    vec_t r;
    r.rst = rst; r.cyc = cyc; r.stb = stb; r.ack = ack;
    r.mux = mux; r.gnt = gnt; r.wcyc = wcyc; r.acko = acko;
    return r;
  endfunction

  vec_t        tbl[$];
  logic [31:0] fadr[NM];
  logic [31:0] fdat[NM];
  logic [3:0]  fsel[NM];
  logic        fwe[NM];

  // Reference model state (spec-level: owner index, phase, rotation, stall count)
  int m_owner, m_phase, m_rr, m_stall, m_timeouts;

  task automatic model_check(input int cyc_n);
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic        e_we, e_cyc, e_stb, e_to;
    logic [NM-1:0] e_gnt, e_ack, e_err, e_rty;
    bit bsy;
    bsy = (m_phase == 1);
    e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0;
    e_adr = '0; e_dat = '0; e_sel = '0; e_we = 0; e_cyc = 0; e_stb = 0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    if (bsy) begin
      e_adr = bus.wbm_adr_i[m_owner];
      e_dat = bus.wbm_dat_i[m_owner];
      e_sel = bus.wbm_sel_i[m_owner];
      e_we  = bus.wbm_we_i[m_owner];
      e_cyc = bus.wbm_cyc_i[m_owner];
      e_stb = bus.wbm_stb_i[m_owner];
      e_ack[m_owner] = bus.wbs_ack_i;
      e_err[m_owner] = bus.wbs_err_i;
      e_rty[m_owner] = bus.wbs_rty_i;
    end
    if (m_phase == 2) e_err[m_owner] = 1'b1;
    e_to = (m_phase == 2);
    chk($sformatf("rnd%0d_grant", cyc_n), grant_o, e_gnt);
    chk($sformatf("rnd%0d_cyc", cyc_n), bus.wbs_cyc_o, e_cyc);
    chk($sformatf("rnd%0d_stb", cyc_n), bus.wbs_stb_o, e_stb);
    chk($sformatf("rnd%0d_adr", cyc_n), bus.wbs_adr_o, e_adr);
    chk($sformatf("rnd%0d_wdat", cyc_n), bus.wbs_dat_o, e_dat);
    chk($sformatf("rnd%0d_sel_we", cyc_n), {bus.wbs_sel_o, bus.wbs_we_o}, {e_sel, e_we});
    chk($sformatf("rnd%0d_resp", cyc_n), {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o},
        {e_ack, e_err, e_rty});
    chk($sformatf("rnd%0d_timeout", cyc_n), timeout_o, e_to);
    chk($sformatf("rnd%0d_rdat", cyc_n), bus.wbm_dat_o, bus.wbs_dat_i);
  endtask

  task automatic model_step();
    bit any_resp;
    any_resp = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
    case (m_phase)
      0: begin
        for (int i = 0; i < NM; i++) begin
          int k;
          k = (m_rr + i) % NM;
          if (m_phase == 0 && bus.wbm_cyc_i[k]) begin
            m_owner = k; m_phase = 1; m_stall = 0;
          end
        end
      end
      1: begin
        if (!bus.wbm_cyc_i[m_owner]) begin
          m_rr = (m_owner + 1) % NM; m_owner = -1; m_phase = 0; m_stall = 0;
        end else if (bus.wbm_stb_i[m_owner] && !any_resp) begin
          m_stall++;
          if (m_stall == TO) begin
            m_phase = 2; m_stall = 0; m_timeouts++;
          end
        end else begin
          m_stall = 0;
        end
      end
      default: begin
        m_rr = (m_owner + 1) % NM; m_owner = -1; m_phase = 0;
      end
    endcase
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0;
    bus.wbs_ack_i = 0; bus.wbs_err_i = 0; bus.wbs_rty_i = 0;
    tick();
    wb_rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_sel_i = '0; bus.wbm_we_i = '0;
    bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0;
    bus.wbs_dat_i = '0; bus.wbs_ack_i = 0; bus.wbs_err_i = 0; bus.wbs_rty_i = 0;
    #1;

    // ---------------- table-driven: single transfer, rotation, multi-strobe
    fadr[0] = 32'h2000_0000; fdat[0] = 32'hDEAD_BEEF; fsel[0] = 4'hF; fwe[0] = 1'b1;
    fadr[1] = 32'h3000_0004; fdat[1] = 32'h1234_5678; fsel[1] = 4'h3; fwe[1] = 1'b0;
    for (int k = 0; k < NM; k++) begin
      bus.wbm_adr_i[k] = fadr[k]; bus.wbm_dat_i[k] = fdat[k];
      bus.wbm_sel_i[k] = fsel[k]; bus.wbm_we_i[k]  = fwe[k];
    end
    //                rst cyc    stb    ack mux gnt    wcyc acko
    tbl.push_back(v(1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00)); // reset state
    tbl.push_back(v(0, 2'b01, 2'b01, 0, 0, 2'b00, 0, 2'b00)); // m0 request, idle
    tbl.push_back(v(0, 2'b01, 2'b01, 0, 1, 2'b01, 1, 2'b00)); // 1-cycle latency
    tbl.push_back(v(0, 2'b01, 2'b01, 0, 1, 2'b01, 1, 2'b00));
    tbl.push_back(v(0, 2'b01, 2'b01, 1, 1, 2'b01, 1, 2'b01)); // ack to m0
    tbl.push_back(v(0, 2'b00, 2'b00, 0, 1, 2'b01, 0, 2'b00)); // release
    tbl.push_back(v(0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00)); // grant cleared
    tbl.push_back(v(1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00)); // reset -> rr=0
    tbl.push_back(v(0, 2'b11, 2'b11, 0, 0, 2'b00, 0, 2'b00)); // both request
    tbl.push_back(v(0, 2'b11, 2'b11, 1, 1, 2'b01, 1, 2'b01)); // m0 first
    tbl.push_back(v(0, 2'b10, 2'b10, 0, 1, 2'b01, 0, 2'b00)); // m0 releases
    tbl.push_back(v(0, 2'b10, 2'b10, 0, 0, 2'b00, 0, 2'b00)); // idle gap
    tbl.push_back(v(0, 2'b10, 2'b10, 1, 1, 2'b10, 1, 2'b10)); // m1 granted
    tbl.push_back(v(0, 2'b00, 2'b00, 0, 1, 2'b10, 0, 2'b00));
    tbl.push_back(v(0, 2'b11, 2'b11, 0, 0, 2'b00, 0, 2'b00)); // both again
    tbl.push_back(v(0, 2'b11, 2'b11, 1, 1, 2'b01, 1, 2'b01)); // rotation -> m0
    tbl.push_back(v(0, 2'b10, 2'b10, 0, 1, 2'b01, 0, 2'b00));
    tbl.push_back(v(0, 2'b10, 2'b10, 0, 0, 2'b00, 0, 2'b00));
    tbl.push_back(v(0, 2'b11, 2'b10, 0, 1, 2'b10, 1, 2'b00)); // m1 owns, m0 waits
    tbl.push_back(v(0, 2'b11, 2'b11, 1, 1, 2'b10, 1, 2'b10)); // strobe 1
    tbl.push_back(v(0, 2'b11, 2'b11, 0, 1, 2'b10, 1, 2'b00));
    tbl.push_back(v(0, 2'b11, 2'b11, 1, 1, 2'b10, 1, 2'b10)); // strobe 2
    tbl.push_back(v(0, 2'b11, 2'b11, 1, 1, 2'b10, 1, 2'b10)); // strobe 3
    tbl.push_back(v(0, 2'b01, 2'b01, 0, 1, 2'b10, 0, 2'b00)); // m1 releases
    tbl.push_back(v(0, 2'b01, 2'b01, 0, 0, 2'b00, 0, 2'b00));
    tbl.push_back(v(0, 2'b01, 2'b01, 1, 1, 2'b01, 1, 2'b01)); // m0 finally
    tbl.push_back(v(0, 2'b00, 2'b00, 0, 1, 2'b01, 0, 2'b00));
    tbl.push_back(v(0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00));

    for (int i = 0; i < tbl.size(); i++) begin
      int gi;
      wb_rst_i      = tbl[i].rst;
      bus.wbm_cyc_i = tbl[i].cyc;
      bus.wbm_stb_i = tbl[i].stb;
      bus.wbs_ack_i = tbl[i].ack;
      bus.wbs_dat_i = $urandom;
      @(negedge wb_clk_i);
      gi = (tbl[i].gnt == 2'b10) ? 1 : 0;
      chk($sformatf("tbl%0d_grant", i), grant_o, tbl[i].gnt);
      chk($sformatf("tbl%0d_cyc", i), bus.wbs_cyc_o, tbl[i].wcyc);
      chk($sformatf("tbl%0d_stb", i), bus.wbs_stb_o, tbl[i].mux ? tbl[i].stb[gi] : 1'b0);
      chk($sformatf("tbl%0d_adr", i), bus.wbs_adr_o, tbl[i].mux ? fadr[gi] : 32'h0);
      chk($sformatf("tbl%0d_wdat", i), bus.wbs_dat_o, tbl[i].mux ? fdat[gi] : 32'h0);
      chk($sformatf("tbl%0d_sel_we", i), {bus.wbs_sel_o, bus.wbs_we_o},
          tbl[i].mux ? {fsel[gi], fwe[gi]} : 5'h0);
      chk($sformatf("tbl%0d_ack", i), bus.wbm_ack_o, tbl[i].acko);
      chk($sformatf("tbl%0d_err_rty", i), {bus.wbm_err_o, bus.wbm_rty_o}, 4'h0);
      chk($sformatf("tbl%0d_timeout", i), timeout_o, 1'b0);
      chk($sformatf("tbl%0d_rdat", i), bus.wbm_dat_o, bus.wbs_dat_i);
      tick();
    end

    // ---------------- watchdog abort on unmapped address
    bus.wbm_adr_i[0] = 32'h5000_0000;
    do_reset();
    bus.wbm_cyc_i = 2'b01; bus.wbm_stb_i = 2'b01;
    @(negedge wb_clk_i); chk("to_idle_cyc", bus.wbs_cyc_o, 1'b0); tick();
    for (int k = 1; k <= TO; k++) begin
      @(negedge wb_clk_i);
      chk($sformatf("to_stall%0d_cyc", k), bus.wbs_cyc_o, 1'b1);
      chk($sformatf("to_stall%0d_err_to", k), {bus.wbm_err_o, timeout_o}, 3'b000);
      tick();
    end
    @(negedge wb_clk_i);
    chk("to_abort_cyc_stb", {bus.wbs_cyc_o, bus.wbs_stb_o}, 2'b00);
    chk("to_abort_err", bus.wbm_err_o, 2'b01);
    chk("to_abort_pulse", timeout_o, 1'b1);
    bus.wbm_cyc_i = 2'b00; bus.wbm_stb_i = 2'b00;
    tick();
    @(negedge wb_clk_i);
    chk("to_after_err_to", {bus.wbm_err_o, timeout_o}, 3'b000);
    chk("to_after_grant", grant_o, 2'b00);
    tick();

    // ---------------- ack coincides with expiry cycle: response wins
    do_reset();
    bus.wbm_cyc_i = 2'b01; bus.wbm_stb_i = 2'b01;
    tick();
    for (int k = 1; k < TO; k++) tick();
    bus.wbs_ack_i = 1;
    @(negedge wb_clk_i);
    chk("race_ack", bus.wbm_ack_o, 2'b01);
    chk("race_err_to", {bus.wbm_err_o, timeout_o}, 3'b000);
    tick();
    bus.wbs_ack_i = 0;
    @(negedge wb_clk_i);
    chk("race_after_cyc", bus.wbs_cyc_o, 1'b1);
    chk("race_after_err_to", {bus.wbm_err_o, timeout_o}, 3'b000);
    bus.wbm_cyc_i = 2'b00; bus.wbm_stb_i = 2'b00;
    tick(); tick();

    // ---------------- async reset mid-BUSY, then arbitration restarts at rr=0
    do_reset();
    bus.wbm_cyc_i = 2'b01; bus.wbm_stb_i = 2'b01; bus.wbs_ack_i = 1;
    tick(); tick();                            // m0 served, rr -> 1 after release
    bus.wbm_cyc_i = 2'b00; bus.wbm_stb_i = 2'b00; bus.wbs_ack_i = 0;
    tick(); tick();
    bus.wbm_cyc_i = 2'b10; bus.wbm_stb_i = 2'b10;
    tick();                                    // m1 now owns
    #2;
    chk("rst_pre_cyc", bus.wbs_cyc_o, 1'b1);
    chk("rst_pre_grant", grant_o, 2'b10);
    wb_rst_i = 1'b1;
    #1;
    chk("rst_async_cyc", bus.wbs_cyc_o, 1'b0);
    chk("rst_async_grant", grant_o, 2'b00);
    chk("rst_async_resp", {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}, 6'h0);
    #1;
    wb_rst_i = 1'b0;
    bus.wbm_cyc_i = 2'b11; bus.wbm_stb_i = 2'b11;
    tick();
    @(negedge wb_clk_i);
    chk("rst_rr_zero_grant", grant_o, 2'b01);
    bus.wbm_cyc_i = 2'b00; bus.wbm_stb_i = 2'b00;
    tick(); tick();

    // ---------------- randomized traffic against the reference model
    do_reset();
    m_owner = -1; m_phase = 0; m_rr = 0; m_stall = 0; m_timeouts = 0;
    for (int n = 0; n < 800; n++) begin
      bit dead;
      for (int k = 0; k < NM; k++) begin
        if (!bus.wbm_cyc_i[k]) begin
          if ($urandom_range(99) < 30) begin
            bus.wbm_cyc_i[k] = 1'b1;
            bus.wbm_stb_i[k] = 1'b1;
            bus.wbm_adr_i[k] = $urandom;
            bus.wbm_dat_i[k] = $urandom;
            bus.wbm_sel_i[k] = 4'($urandom);
            bus.wbm_we_i[k]  = 1'($urandom);
          end
        end else if ($urandom_range(99) < 5) begin
          bus.wbm_cyc_i[k] = 1'b0;
          bus.wbm_stb_i[k] = 1'b0;
        end else begin
          bus.wbm_stb_i[k] = ($urandom_range(99) < 85);
          if ($urandom_range(99) < 20) bus.wbm_adr_i[k] = $urandom;
        end
      end
      dead = ((n / 40) % 3 == 2);
      bus.wbs_ack_i = !dead && ($urandom_range(99) < 40);
      bus.wbs_err_i = !dead && ($urandom_range(99) < 5);
      bus.wbs_rty_i = !dead && ($urandom_range(99) < 5);
      bus.wbs_dat_i = $urandom;
      @(negedge wb_clk_i);
      model_check(n);
      @(posedge wb_clk_i);
      model_step();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Shares the single Wishbone classic master port of the SoC interconnect (wb_io_*) between NUM_MASTERS requesters: CPU instruction fetch, CPU load/store, and a debug/DMA port.
- Arbitration is round-robin with ownership held for the whole cyc assertion.
- A per-transfer watchdog terminates hung accesses to unmapped or stalled slaves with err.
- Sits between the requesters and the interconnect's wb_io port.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 255, cycles without ack/err/rty before abort; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset.
- wbm_adr_i  in  NUM_MASTERS*32  requester addresses; master k occupies bits [32k+31:32k].
- wbm_dat_i  in  NUM_MASTERS*32  requester write data.
- wbm_sel_i  in  NUM_MASTERS*4  byte selects.
- wbm_we_i  in  NUM_MASTERS  write enables.
- wbm_cyc_i  in  NUM_MASTERS  cycle requests.
- wbm_stb_i  in  NUM_MASTERS  strobes.
- wbm_dat_o  out  32  read data, broadcast to all requesters.
- wbm_ack_o  out  NUM_MASTERS  per-requester ack.
- wbm_err_o  out  NUM_MASTERS  per-requester err.
- wbm_rty_o  out  NUM_MASTERS  per-requester rty.
- wbs_adr_o  out  32  to interconnect wb_io_adr_i.
- wbs_dat_o  out  32  to interconnect wb_io_dat_i.
- wbs_sel_o  out  4  to interconnect wb_io_sel_i.
- wbs_we_o  out  1  to interconnect wb_io_we_i.
- wbs_cyc_o  out  1  to interconnect wb_io_cyc_i.
- wbs_stb_o  out  1  to interconnect wb_io_stb_i.
- wbs_dat_i  in  32  from interconnect.
- wbs_ack_i  in  1  from interconnect.
- wbs_err_i  in  1  from interconnect.
- wbs_rty_i  in  1  from interconnect.
- grant_o  out  NUM_MASTERS  one-hot current owner, registered.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_i is asynchronous, active-high.
- Reset values: state IDLE, grant_o=0, rr pointer=0, watchdog=0, timeout_o=0. All wbs_cyc/stb/we and wbm_ack/err/rty outputs are 0; adr/dat/sel outputs are 0.
- A reset during a transfer drops wbs_cyc_o immediately (asynchronous). No response is returned to the interrupted requester.
- IDLE:
  - wbs_cyc_o=wbs_stb_o=0.
  - If any wbm_cyc_i is high, select the first requester with cyc high, searching from index rr upward with wrap. Register it into grant_o and go to BUSY.
  - Arbitration latency is exactly 1 cycle from cyc to wbs_cyc_o.
- BUSY:
  - wbs_adr/dat/sel/we/cyc/stb_o combinationally follow the granted requester.
  - wbs_ack/err/rty_i are routed only to the granted bit; other bits are 0.
  - wbm_dat_o = wbs_dat_i at all times.
  - Ownership is held across multiple strobes while the owner's cyc stays high; other requesters wait with no response.
  - When the owner drops cyc: go to IDLE, set rr = owner+1 mod NUM_MASTERS, clear grant_o next cycle.
  - Back-to-back requests therefore see one idle bus cycle between owners.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counts cycles in BUSY where wbs_stb_o=1 and no ack/err/rty is present.
  - Clears on any slave response, on stb low, and on leaving BUSY.
  - When the count reaches TIMEOUT_CYCLES, go to ABORT.
  - If a slave response and expiry coincide, the response wins and no abort occurs.
- ABORT (exactly 1 cycle):
  - wbs_cyc_o=wbs_stb_o=0.
  - wbm_err_o[owner]=1 and timeout_o=1.
  - rr = owner+1; next state IDLE, where normal rearbitration applies (the owner may win again if it is the only requester).
- Requesters with stb low but cyc high keep ownership indefinitely; the watchdog does not count in that case.
- A requester that drops cyc while not granted simply leaves the arbitration.

Test Plan:
- Single master 0, write 0xDEADBEEF to 0x20000000, slave acks 2 cycles after stb -> wbs_cyc_o rises 1 cycle after wbm_cyc_i[0]; wbm_ack_o=2'b01 for 1 cycle; grant_o=01 then 00.
- Both masters raise cyc in the same cycle after reset -> master 0 granted first. After it releases: one idle cycle, then master 1 granted. A third simultaneous request goes to master 0 again (rotation verified).
- Master 1 issues 3 back-to-back strobes under one cyc while master 0 requests -> all 3 acks go to master 1; master 0 sees no ack/err/rty until master 1 drops cyc.
- Access to unmapped 0x50000000 with TIMEOUT_CYCLES=8, no slave response -> after 8 stalled cycles: wbs_cyc_o low, wbm_err_o[owner]=1 and timeout_o=1 for exactly 1 cycle, state returns to IDLE.
- Slave ack arrives in the exact cycle the watchdog would expire -> ack delivered, no err, timeout_o stays 0.
- wb_rst_i asserted mid-BUSY with stb high -> wbs_cyc_o and grant_o go 0 without a clock edge; after release, the first request is arbitrated from rr=0.
